ts_descriptor_release_module: RTL and testbench

TS_DESCRIPTOR_RELEASE_MODULE -- requirements
Module: ts_descriptor_release_module

---
 rtl/ts_descriptor_release_module.sv | 122 ++++++++++++
 tb/tb_ts_descriptor_release_module.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_descriptor_release_module.sv
// Buffers host TS descriptors per injection address and releases one
// per scheduled address. Host write port, scheduler request/ack, and
// downstream valid/ready. Also release, miss and overwrite counters.
module ts_descriptor_release_module (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  iv_hardware_stage,
  input  logic [31:0] iv_ts_descriptor,
  input  logic [4:0]  iv_ts_descriptor_addr,
  input  logic        i_ts_descriptor_wr,
  input  logic [4:0]  iv_ts_injection_addr,
  input  logic        i_ts_injection_addr_wr,
  output logic        o_ts_injection_addr_ack,
  output logic [31:0] ov_ts_descriptor,
  output logic        o_ts_descriptor_wr,
  input  logic        i_ts_descriptor_ready,
  output logic [15:0] ov_release_cnt,
  output logic [15:0] ov_miss_cnt,
  output logic [15:0] ov_overwrite_cnt,
  output logic [1:0]  ov_trm_state
);

  typedef enum logic [1:0] {
    INIT_S   = 2'd0,
    IDLE_S   = 2'd1,
    LOOKUP_S = 2'd2,
    OUTPUT_S = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] mem [32];
  logic [31:0] vld;
  logic [4:0]  lk_addr;
  logic [15:0] rel_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] ovw_cnt;
  logic        rel_hit;
  logic        same_rel;

  assign rel_hit  = (state == LOOKUP_S) && vld[lk_addr];
  // A host write landing on the entry being released is a refill,
  // not an overwrite of unreleased data.
  assign same_rel = rel_hit && i_ts_descriptor_wr &&
                    (iv_ts_descriptor_addr == lk_addr);

  assign ov_release_cnt   = rel_cnt;
  assign ov_miss_cnt      = miss_cnt;
  assign ov_overwrite_cnt = ovw_cnt;
  assign ov_trm_state     = state;

  // Data contents carry no reset; validity is tracked in vld.
  always_ff @(posedge i_clk) begin
    if (i_ts_descriptor_wr)
      mem[iv_ts_descriptor_addr] <= iv_ts_descriptor;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld     <= '0;
      ovw_cnt <= '0;
    end else begin
      if (rel_hit)
        vld[lk_addr] <= 1'b0;
      // Later assignment wins: a same-cycle write leaves the entry valid.
      if (i_ts_descriptor_wr)
        vld[iv_ts_descriptor_addr] <= 1'b1;
      if (i_ts_descriptor_wr && vld[iv_ts_descriptor_addr] && !same_rel)
        ovw_cnt <= ovw_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                   <= INIT_S;
      lk_addr                 <= '0;
      o_ts_injection_addr_ack <= 1'b0;
      o_ts_descriptor_wr      <= 1'b0;
      ov_ts_descriptor        <= '0;
      rel_cnt                 <= '0;
      miss_cnt                <= '0;
    end else begin
      o_ts_injection_addr_ack <= 1'b0;
      case (state)
        INIT_S: begin
          if (iv_hardware_stage == 3'd3)
            state <= IDLE_S;
        end
        IDLE_S: begin
          if (i_ts_injection_addr_wr) begin
            lk_addr                 <= iv_ts_injection_addr;
            o_ts_injection_addr_ack <= 1'b1;
            state                   <= LOOKUP_S;
          end
        end
        LOOKUP_S: begin
          if (vld[lk_addr]) begin
            ov_ts_descriptor   <= mem[lk_addr];
            o_ts_descriptor_wr <= 1'b1;
            rel_cnt            <= rel_cnt + 16'd1;
            state              <= OUTPUT_S;
          end else begin
            miss_cnt <= miss_cnt + 16'd1;
            state    <= IDLE_S;
          end
        end
        OUTPUT_S: begin
          if (i_ts_descriptor_ready) begin
            o_ts_descriptor_wr <= 1'b0;
            ov_ts_descriptor   <= '0;
            state              <= IDLE_S;
          end
        end
        default: begin
          o_ts_descriptor_wr      <= 1'b0;
          o_ts_injection_addr_ack <= 1'b0;
          state                   <= IDLE_S;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_descriptor_release_module.sv
// Scoreboard bench for ts_descriptor_release_module: a per-address
// buffer model predicts releases, misses and overwrites.
module tb_ts_descriptor_release_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  stage = '0;
  logic [31:0] hd = '0;
  logic [4:0]  ha = '0;
  logic        hw_s = 1'b0;
  logic [4:0]  ia = '0;
  logic        iw = 1'b0;
  logic        ack;
  logic [31:0] od;
  logic        owr;
  logic        rdy = 1'b1;
  logic [15:0] rel, miss, ovw;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [31:0] m_mem [32];
  bit          m_vld [32];
  int          m_rel = 0, m_miss = 0, m_ovw = 0;
  bit          rnd_rdy = 0;
  bit          mon_en = 0;

  ts_descriptor_release_module dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .iv_hardware_stage       (stage),
    .iv_ts_descriptor        (hd),
    .iv_ts_descriptor_addr   (ha),
    .i_ts_descriptor_wr      (hw_s),
    .iv_ts_injection_addr    (ia),
    .i_ts_injection_addr_wr  (iw),
    .o_ts_injection_addr_ack (ack),
    .ov_ts_descriptor        (od),
    .o_ts_descriptor_wr      (owr),
    .i_ts_descriptor_ready   (rdy),
    .ov_release_cnt          (rel),
    .ov_miss_cnt             (miss),
    .ov_overwrite_cnt        (ovw),
    .ov_trm_state            (st)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_vld[i] = 0;
    m_rel = 0; m_miss = 0; m_ovw = 0;
  endtask

  task automatic model_lookup(input int a);
    if (m_vld[a]) begin
      q.push_back(m_mem[a]);
      m_vld[a] = 0;
      m_rel++;
    end else begin
      m_miss++;
    end
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    if (m_vld[a]) m_ovw++;
    m_mem[a] = d;
    m_vld[a] = 1;
    ha = 5'(a); hd = d; hw_s = 1'b1;
    tick();
    hw_s = 1'b0;
  endtask

  task automatic sched(input int a);
    bit got = 0;
    ia = 5'(a); iw = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      tick();
      if (ack === 1'b1) got = 1;
    end
    iw = 1'b0;
    if (got) model_lookup(a);
    else chk("sched_ack_timeout", 32'(ack), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      tick();
      if (st == 2'd1 && !owr) ok = 1;
    end
    if (!ok) chk("idle_timeout", 32'(st), 32'd1);
  endtask

  task automatic chk_cnts();
    chk("release_cnt", 32'(rel), m_rel & 32'hFFFF);
    chk("miss_cnt", 32'(miss), m_miss & 32'hFFFF);
    chk("overwrite_cnt", 32'(ovw), m_ovw & 32'hFFFF);
  endtask

  // Monitor: pops on each downstream handshake and checks output hold,
  // clear-after-accept, and single-cycle ack.
  logic        pv_wr = 0, pv_take = 0, pv_ack = 0;
  logic [31:0] pv_d = '0;
  always @(negedge clk) begin
    if (!mon_en) begin
      pv_wr = 0; pv_take = 0; pv_ack = 0;
    end else begin
      if (pv_wr && !pv_take) begin
        chk("hold_wr", 32'(owr), 32'd1);
        chk("hold_data", od, pv_d);
      end
      if (pv_take) begin
        chk("drop_wr", 32'(owr), 32'd0);
        chk("drop_data", od, 32'd0);
      end
      if (pv_ack) chk("ack_pulse", 32'(ack), 32'd0);
      if (owr && rdy) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_desc actual=%0h required=none", od);
        end else begin
          chk("desc", od, q.pop_front());
        end
      end
      pv_wr = owr; pv_take = owr && rdy; pv_d = od; pv_ack = ack;
    end
  end

  initial begin
    int a;
    model_clear();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wr", 32'(owr), 32'd0);
    chk("rst_data", od, 32'd0);
    chk_cnts();

    // Not configured: request must wait
    stage = 3'd1; ia = 5'd2; iw = 1'b1;
    repeat (4) begin
      tick();
      chk("init_no_ack", 32'(ack), 32'd0);
      chk("init_state", 32'(st), 32'd0);
    end
    stage = 3'd3;
    sched(2);
    wait_idle();
    chk("idle_state", 32'(st), 32'd1);
    chk_cnts();

    // Basic release with latency check
    host_wr(4, 32'hA5A5_0001);
    ia = 5'd4; iw = 1'b1;
    tick();
    chk("lat_ack", 32'(ack), 32'd1);
    chk("lat_wr_early", 32'(owr), 32'd0);
    iw = 1'b0;
    model_lookup(4);
    tick();
    chk("lat_ack_off", 32'(ack), 32'd0);
    chk("lat_wr", 32'(owr), 32'd1);
    chk("lat_data", od, 32'hA5A5_0001);
    wait_idle();
    chk_cnts();
    sched(4);
    wait_idle();
    chk_cnts();

    // Miss
    sched(7);
    wait_idle();
    chk("miss_idle", 32'(st), 32'd1);
    chk_cnts();

    // Downstream stall
    host_wr(10, 32'hC0DE_0010);
    host_wr(11, 32'hC0DE_0011);
    rdy = 1'b0;
    sched(10);
    tick();
    ia = 5'd11; iw = 1'b1;
    repeat (5) begin
      tick();
      chk("stall_ack", 32'(ack), 32'd0);
      chk("stall_wr", 32'(owr), 32'd1);
      chk("stall_data", od, 32'hC0DE_0010);
    end
    rdy = 1'b1;
    sched(11);
    wait_idle();
    chk_cnts();

    // Overwrite and same-cycle refill
    host_wr(3, 32'h11);
    host_wr(3, 32'h22);
    chk_cnts();
    sched(3);
    wait_idle();
    host_wr(3, 32'h44);
    sched(3);
    host_wr(3, 32'h33);
    wait_idle();
    chk_cnts();
    sched(3);
    wait_idle();
    chk_cnts();

    // Same-cycle write during a miss
    sched(9);
    host_wr(9, 32'h55);
    wait_idle();
    chk_cnts();
    sched(9);
    wait_idle();
    chk_cnts();

    // Random traffic, address 31 reserved for misses later
    rnd_rdy = 1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 30);
      else a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) host_wr(a, $urandom);
      else sched(a);
    end
    rnd_rdy = 0;
    rdy = 1'b1;
    wait_idle();
    chk_cnts();

    // Miss counter wrap
    @(negedge clk);
    dut.miss_cnt = 16'hFFFE;
    m_miss = 32'hFFFE;
    sched(31);
    wait_idle();
    chk_cnts();
    sched(31);
    wait_idle();
    chk_cnts();
    chk("miss_wrap", 32'(miss), 32'd0);

    // Reset while a descriptor is pending
    rdy = 1'b0;
    host_wr(5, 32'h77);
    ia = 5'd5; iw = 1'b1;
    tick();
    iw = 1'b0;
    tick();
    chk("pre_rst_wr", 32'(owr), 32'd1);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(owr), 32'd0);
    chk("rst_mid_data", od, 32'd0);
    chk("rst_mid_state", 32'(st), 32'd0);
    model_clear();
    chk_cnts();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    mon_en = 1;
    sched(5);
    wait_idle();
    chk_cnts();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
